// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-port register file with write-to-read bypass and a per-register
//   pending-write scoreboard. Issue marks a destination busy and writeback
//   clears it. Decode stalls on rdBusy or !issueReady. A flush squashes all
//   in-flight writes.
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RES           synchronous active-high reset
//   rdAddr        NRD read addresses, port i at [i*AW +: AW]
//   rdData        NRD combinational read results, port i at [i*XLEN +: XLEN]
//   rdBusy        per port: source still has an unresolved pending write
//   issueValid    an instruction writing issueRd is issuing
//   issueRd       destination of the issuing instruction
//   issueReady    issue accepted this cycle (no WAW hazard)
//   wbValid       writeback strobe
//   wbRd/wbData   writeback destination and data
//   flush         clear the whole scoreboard
//   busyMask      registered busy bit per register
//   pendingCount  registered population count of busyMask
//   wbSpurious    sticky: a writeback hit a register that was not busy
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic [NRD*AW-1:0]     rdAddr,
  output logic [NRD*XLEN-1:0]   rdData,
  output logic [NRD-1:0]        rdBusy,
  input  logic                  issueValid,
  input  logic [AW-1:0]         issueRd,
  output logic                  issueReady,
  input  logic                  wbValid,
  input  logic [AW-1:0]         wbRd,
  input  logic [XLEN-1:0]       wbData,
  input  logic                  flush,
  output logic [NREG-1:0]       busyMask,
  output logic [AW:0]           pendingCount,
  output logic                  wbSpurious
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_q, pend_d;
  logic            spur_q, spur_d;

  logic wb_wr;      // writeback targets a writable register
  logic iss_zero;   // issue targets the hardwired zero register
  logic iss_acc;    // issue is accepted and not squashed

  assign wb_wr    = !((ZERO_REG != 0) && (wbRd == '0));
  assign iss_zero = (ZERO_REG != 0) && (issueRd == '0);

  // A same-cycle writeback to the destination retires the old producer,
  // so the new one may take the register over without a WAW stall.
  assign issueReady = !RES && (!busy_q[issueRd] || (wbValid && (wbRd == issueRd)) || iss_zero);
  assign iss_acc    = issueValid && issueReady && !flush;

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] ra;
      logic          zr;
      logic          hit;
      assign ra  = rdAddr[g*AW +: AW];
      assign zr  = (ZERO_REG != 0) && (ra == '0);
      assign hit = wbValid && wb_wr && (wbRd == ra);
      assign rdData[g*XLEN +: XLEN] = zr ? '0 : (hit ? wbData : regs_q[ra]);
      assign rdBusy[g] = busy_q[ra] && !hit && !zr;
    end
  endgenerate

  // Busy update: flush overrides everything; issue is applied after the
  // writeback clear so a same-register issue+wb leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wbValid) busy_d[wbRd] = 1'b0;
      if (iss_acc && !iss_zero) busy_d[issueRd] = 1'b1;
    end
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NREG; i++) pend_d = pend_d + {{AW{1'b0}}, busy_d[i]};
  end

  assign spur_d = spur_q || (wbValid && wb_wr && !flush && !busy_q[wbRd]);

  always_ff @(posedge CLK) begin
    if (RES) begin
      busy_q <= '0;
      pend_q <= '0;
      spur_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      spur_q <= spur_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wbValid && wb_wr) begin
      regs_q[wbRd] <= wbData;
    end
  end

  assign busyMask     = busy_q;
  assign pendingCount = pend_q;
  assign wbSpurious   = spur_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RES;
  always #5 CLK = ~CLK;

  // default instance: XLEN=32, NREG=32, NRD=2
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        issueValid, issueReady, wbValid, flush, wbSpurious;
  logic [4:0]  issueRd, wbRd;
  logic [31:0] wbData;
  logic [31:0] busyMask;
  logic [5:0]  pendingCount;

  regfile_scoreboard dut (
    .CLK(CLK), .RES(RES), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
    .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData), .flush(flush),
    .busyMask(busyMask), .pendingCount(pendingCount), .wbSpurious(wbSpurious)
  );

  // swept instance: XLEN=64, NREG=16, NRD=3
  logic [11:0]  d2_rdAddr;
  logic [191:0] d2_rdData;
  logic [2:0]   d2_rdBusy;
  logic         d2_issueValid, d2_issueReady, d2_wbValid, d2_flush, d2_wbSpurious;
  logic [3:0]   d2_issueRd, d2_wbRd;
  logic [63:0]  d2_wbData;
  logic [15:0]  d2_busyMask;
  logic [4:0]   d2_pendingCount;

  regfile_scoreboard #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(1)) dut2 (
    .CLK(CLK), .RES(RES), .rdAddr(d2_rdAddr), .rdData(d2_rdData), .rdBusy(d2_rdBusy),
    .issueValid(d2_issueValid), .issueRd(d2_issueRd), .issueReady(d2_issueReady),
    .wbValid(d2_wbValid), .wbRd(d2_wbRd), .wbData(d2_wbData), .flush(d2_flush),
    .busyMask(d2_busyMask), .pendingCount(d2_pendingCount), .wbSpurious(d2_wbSpurious)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the default instance ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_spur;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wbValid && wbRd == a) return wbData;
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(input logic [4:0] a);
    return m_busy[a] && !(wbValid && wbRd == a && a != 0);
  endfunction

  function automatic bit m_ready();
    return !RES && (!m_busy[issueRd] || (wbValid && wbRd == issueRd) || issueRd == 0);
  endfunction

  always @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
      m_spur = 0;
    end else begin
      bit acc;
      acc = issueValid && m_ready() && !flush;
      if (wbValid && wbRd != 0) begin
        if (!flush && !m_busy[wbRd]) m_spur = 1;
        m_regs[wbRd] = wbData;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (wbValid) m_busy[wbRd] = 0;
        if (acc && issueRd != 0) m_busy[issueRd] = 1;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [31:0] mask;
      int          cnt;
      mask = '0;
      cnt  = 0;
      for (int i = 0; i < 32; i++) begin
        mask[i] = m_busy[i];
        cnt += int'(m_busy[i]);
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("cmp_rdData%0d", p), {32'h0, rdData[p*32 +: 32]}, {32'h0, m_read(rdAddr[p*5 +: 5])});
        chk($sformatf("cmp_rdBusy%0d", p), {63'h0, rdBusy[p]}, {63'h0, m_rbusy(rdAddr[p*5 +: 5])});
      end
      chk("cmp_issueReady", {63'h0, issueReady}, {63'h0, m_ready()});
      chk("cmp_busyMask", {32'h0, busyMask}, {32'h0, mask});
      chk("cmp_pendingCount", {58'h0, pendingCount}, 64'(cnt));
      chk("cmp_wbSpurious", {63'h0, wbSpurious}, {63'h0, m_spur});
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    issueValid = 0; wbValid = 0; flush = 0;
    d2_issueValid = 0; d2_wbValid = 0; d2_flush = 0;
  endtask

  initial begin
    RES = 1; idle();
    rdAddr = '0; issueRd = 5'd5; wbRd = '0; wbData = '0;
    d2_rdAddr = '0; d2_issueRd = '0; d2_wbRd = '0; d2_wbData = '0;

    // reset held two cycles
    @(negedge CLK);
    chk("reset_issueReady", {63'h0, issueReady}, 64'h0);
    step();
    RES = 0;
    @(negedge CLK);
    chk("reset_busyMask", {32'h0, busyMask}, 64'h0);
    chk("reset_pendingCount", {58'h0, pendingCount}, 64'h0);
    chk("reset_issueReady_after", {63'h0, issueReady}, 64'h1);
    for (int r = 0; r < 32; r++) begin
      step();
      rdAddr[4:0] = 5'(r);
      @(negedge CLK);
      chk($sformatf("reset_reg%0d", r), {32'h0, rdData[31:0]}, 64'h0);
    end

    // RAW stall and bypass
    step(); issueValid = 1; issueRd = 5'd5;
    step(); idle(); rdAddr[4:0] = 5'd5;
    @(negedge CLK);
    chk("raw_busy5", {63'h0, busyMask[5]}, 64'h1);
    chk("raw_rdBusy0", {63'h0, rdBusy[0]}, 64'h1);
    step(); wbValid = 1; wbRd = 5'd5; wbData = 32'hDEADBEEF;
    @(negedge CLK);
    chk("raw_bypass_data", {32'h0, rdData[31:0]}, 64'hDEADBEEF);
    chk("raw_bypass_busy", {63'h0, rdBusy[0]}, 64'h0);
    step(); idle();
    @(negedge CLK);
    chk("raw_busy5_clear", {63'h0, busyMask[5]}, 64'h0);
    chk("raw_reg5", {32'h0, rdData[31:0]}, 64'hDEADBEEF);

    // WAW
    step(); issueValid = 1; issueRd = 5'd7;
    step();
    @(negedge CLK);
    chk("waw_ready_blocked", {63'h0, issueReady}, 64'h0);
    step(); wbValid = 1; wbRd = 5'd7; wbData = 32'h77;
    @(negedge CLK);
    chk("waw_busy_unchanged", {32'h0, busyMask}, 64'h80);
    chk("waw_ready_with_wb", {63'h0, issueReady}, 64'h1);
    step(); idle();
    @(negedge CLK);
    chk("waw_busy7_kept", {32'h0, busyMask}, 64'h80);
    chk("waw_pendingCount", {58'h0, pendingCount}, 64'h1);
    chk("waw_no_spurious", {63'h0, wbSpurious}, 64'h0);
    step(); wbValid = 1; wbRd = 5'd7; wbData = 32'h78;
    step(); idle();

    // flush
    issueValid = 1; issueRd = 5'd3;
    step(); issueRd = 5'd4;
    step(); issueRd = 5'd9;
    step(); idle();
    @(negedge CLK);
    chk("flush_pre_count", {58'h0, pendingCount}, 64'h3);
    chk("flush_pre_mask", {32'h0, busyMask}, 64'h218);
    step(); flush = 1; issueValid = 1; issueRd = 5'd10; wbValid = 1; wbRd = 5'd4; wbData = 32'h55;
    step(); idle(); rdAddr = {5'd10, 5'd4};
    @(negedge CLK);
    chk("flush_mask", {32'h0, busyMask}, 64'h0);
    chk("flush_count", {58'h0, pendingCount}, 64'h0);
    chk("flush_reg4", {32'h0, rdData[31:0]}, 64'h55);
    chk("flush_busy10", {63'h0, rdBusy[1]}, 64'h0);

    // zero register and spurious writeback
    step(); issueValid = 1; issueRd = 5'd0;
    step(); idle();
    @(negedge CLK);
    chk("zero_issue_mask", {32'h0, busyMask}, 64'h0);
    step(); wbValid = 1; wbRd = 5'd0; wbData = 32'h1234; rdAddr[4:0] = 5'd0;
    @(negedge CLK);
    chk("zero_bypass", {32'h0, rdData[31:0]}, 64'h0);
    step(); idle();
    @(negedge CLK);
    chk("zero_read", {32'h0, rdData[31:0]}, 64'h0);
    chk("zero_no_spurious", {63'h0, wbSpurious}, 64'h0);
    step(); wbValid = 1; wbRd = 5'd12; wbData = 32'h1;
    step(); wbRd = 5'd31; wbData = 32'hFFFFFFFF;
    step(); idle(); rdAddr = {5'd31, 5'd12};
    @(negedge CLK);
    chk("spur_reg12", {32'h0, rdData[31:0]}, 64'h1);
    chk("spur_reg31", {32'h0, rdData[63:32]}, 64'hFFFFFFFF);
    chk("spur_set", {63'h0, wbSpurious}, 64'h1);
    step(); step(); step();
    @(negedge CLK);
    chk("spur_sticky", {63'h0, wbSpurious}, 64'h1);

    // swept instance: duplicate-port bypass on 64-bit data
    step(); d2_wbValid = 1; d2_wbRd = 4'd15; d2_wbData = 64'h0123456789ABCDEF;
    step(); d2_wbRd = 4'd1; d2_wbData = 64'hCAFEBABE12345678;
    d2_rdAddr = {4'd15, 4'd1, 4'd1};
    @(negedge CLK);
    chk("p3_port0_bypass", d2_rdData[63:0], 64'hCAFEBABE12345678);
    chk("p3_port1_bypass", d2_rdData[127:64], 64'hCAFEBABE12345678);
    chk("p3_port2_stored", d2_rdData[191:128], 64'h0123456789ABCDEF);
    chk("p3_rdBusy", {61'h0, d2_rdBusy}, 64'h0);
    step(); idle();
    @(negedge CLK);
    chk("p3_port0_stored", d2_rdData[63:0], 64'hCAFEBABE12345678);
    chk("p3_spurious", {63'h0, d2_wbSpurious}, 64'h1);

    // reset clears sticky flag and register contents
    step(); RES = 1;
    step(); RES = 0; rdAddr[4:0] = 5'd5;
    @(negedge CLK);
    chk("rst2_spurious", {63'h0, wbSpurious}, 64'h0);
    chk("rst2_reg5", {32'h0, rdData[31:0]}, 64'h0);
    chk("rst2_d2_count", {59'h0, d2_pendingCount}, 64'h0);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's plain 2-read/1-write register file.
- Adds: configurable XLEN, register count and read-port count; write-to-read bypass; a per-register pending-write scoreboard for RAW/WAW hazard detection; pipeline flush.
- Sits in decode. Issue logic marks destinations pending; writeback clears them. Decode stalls on rdBusy or !issueReady.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, >= 2). AW = clog2(NREG).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RES  in  1  reset. One clock; reset is synchronous and active-high.
- rdAddr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rdData  out  NRD*XLEN  read data (combinational), port i at [i*XLEN +: XLEN].
- rdBusy  out  NRD  port i source has an unresolved pending write.
- issueValid  in  1  decode issues an instruction writing issueRd.
- issueRd  in  AW  destination of the issuing instruction.
- issueReady  out  1  issue is accepted this cycle (no WAW hazard).
- wbValid  in  1  writeback strobe.
- wbRd  in  AW  writeback destination.
- wbData  in  XLEN  writeback data.
- flush  in  1  squash all in-flight writes; clears the scoreboard.
- busyMask  out  NREG  registered busy bit per register.
- pendingCount  out  AW+1  registered population count of busyMask.
- wbSpurious  out  1  sticky flag: a writeback targeted a non-busy register.

Behaviour:
- Reset (RES=1 at edge): all registers = 0, busyMask = 0, pendingCount = 0, wbSpurious = 0. issueReady is forced 0 while RES=1.
- Zero register (ZERO_REG=1):
  - Reads of register 0 return 0.
  - Writes to register 0 are dropped.
  - rdBusy is 0 for register 0, and issue of register 0 never sets busy.
- Write: on an edge with wbValid=1 and wbRd writable, regs[wbRd] <= wbData. This is a one-cycle write, independent of flush.
- Bypass: rdData[i] = wbData when wbValid and wbRd==rdAddr[i] and the register is writable; otherwise regs[rdAddr[i]]. Zero latency.
- rdBusy[i] = busy[rdAddr[i]] & !(bypass hit on port i).
- issueReady = !RES & (!busy[issueRd] | (wbValid & wbRd==issueRd) | issueRd is zero reg). It is combinational.
- Accepted issue = issueValid & issueReady & !flush. On an accepted issue, busy[issueRd] <= 1 next edge.
- Busy update priority at each edge:
  1. RES
  2. flush: busy <= 0 entirely; a same-cycle issue is ignored, while a same-cycle wb data write still happens.
  3. accepted issue: set bit.
  4. wbValid: clear bit.
- Issue and wb to the same register in the same cycle leaves the bit set (the new producer wins).
- Issue and wb to different registers both take effect.
- wbValid with busy[wbRd]=0 and not flushing: the data is still written and wbSpurious <= 1 (sticky until RES). Writes to register 0 never set wbSpurious.
- pendingCount always equals popcount(busyMask) of the same cycle. Both are registered.
- Read-port count scaling: all NRD ports are fully independent. Duplicate addresses across ports return identical data and busy.

Test Plan:
- Reset then idle: RES high 2 cycles, read all regs via port 0 -> every rdData=0, busyMask=0, pendingCount=0, issueReady=1 after RES drops.
- RAW stall + bypass: issue rd=5 -> next cycle busyMask[5]=1, rdAddr0=5 gives rdBusy[0]=1. Assert wbValid, wbRd=5, wbData=0xDEADBEEF -> same cycle rdData0=0xDEADBEEF and rdBusy[0]=0. Next cycle busy[5]=0 and reg5 reads 0xDEADBEEF.
- WAW: reg7 busy, issueRd=7 -> issueReady=0 and busy unchanged. Same cycle with wb to 7 -> issueReady=1 and busy[7] stays 1, pendingCount=1.
- Flush: issue rd=3, 4, 9 -> pendingCount=3. Pulse flush together with issueValid rd=10 and wb rd=4 data 0x55 -> busyMask=0, pendingCount=0, reg4=0x55, busy[10]=0.
- Zero register and spurious write: issue rd=0 -> busyMask=0. wb rd=0 data 0x1234 -> reg0 reads 0 and wbSpurious=0. wb rd=12 (not busy) data 0x1 -> reg12=1 and wbSpurious=1, staying 1 until RES.
- Parameter sweep XLEN=64, NREG=16, NRD=3: three ports read regs 1, 1, 15 during a wb to 1 -> ports 0 and 1 bypass the identical 64-bit value and port 2 returns its stored value.
